// File: rtl/float_pack.sv
// Shared float format for the LM32 coprocessor datapath plus the multiplier's state
// encoding and helpers.
package float_pack;

    localparam int Ne   = 8;
    localparam int Nm   = 23;
    localparam int BIAS = 2**(Ne-1) - 1;

    typedef struct packed {
        logic          s;
        logic [Ne-1:0] e;
        logic [Nm-1:0] m;
    } float;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} fmul_state_t;

    // Denormals are flushed, so a zero exponent field means the operand is zero.
    function automatic logic float_is_zero(input float f);
        return f.e == '0;
    endfunction

endpackage

// File: rtl/float_mul_unit_if.sv
// Request/response bundle of float_mul_unit; the unit sits on the slave side.
interface float_mul_unit_if;
    import float_pack::*;

    logic start_i;
    float op1_i;
    float op2_i;
    logic busy_o;
    logic done_o;
    float res_o;

    modport master (output start_i, op1_i, op2_i, input busy_o, done_o, res_o);
    modport slave  (input start_i, op1_i, op2_i, output busy_o, done_o, res_o);

endinterface

// File: rtl/float_mul_unit_mant_shift_add_mul.sv
// Unsigned W x W iterative shift-add multiplier: one partial product per cycle after load_i,
// done_o marks the last step, prod_o is complete the cycle after.
module mant_shift_add_mul #(
    parameter int W = 24
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           load_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           done_o,
    output logic [2*W-1:0] prod_o
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    logic [W-1:0]  mcand_q;
    logic [2*W:0]  preg_q, preg_d;
    logic [CW-1:0] cnt_q;
    logic          run_q;
    logic [W:0]    upper;

    // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
    always_comb begin
        upper  = preg_q[2*W:W] + (preg_q[0] ? {1'b0, mcand_q} : '0);
        preg_d = {upper, preg_q[W-1:0]} >> 1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q <= '0;
            preg_q  <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else if (load_i) begin
            mcand_q <= a_i;
            preg_q  <= {{(W+1){1'b0}}, b_i};
            cnt_q   <= '0;
            run_q   <= 1'b1;
        end else if (run_q) begin
            preg_q <= preg_d;
            if (cnt_q == CNT_LAST) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign done_o = run_q && (cnt_q == CNT_LAST);
    assign prod_o = preg_q[2*W-1:0];

endmodule

// File: rtl/float_mul_unit.sv
// Iterative float multiplier: FSM, exponent path and normalization around mant_shift_add_mul.
// Define FLOAT_MUL_ROUND_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module float_mul_unit
    import float_pack::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    float_mul_unit_if.slave bus
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_MUL  = MUL;
    localparam logic [1:0] ST_NORM = NORM;
    localparam logic [1:0] ST_DONE = DONE;

    localparam int PW = 2*Nm + 2;
    localparam logic signed [Ne+1:0] BIAS_W  = (Ne+2)'(BIAS);
    localparam logic signed [Ne+1:0] EXP_MAX = (Ne+2)'(2**Ne - 1);
    localparam logic signed [Ne+1:0] EXP_ONE = (Ne+2)'(1);

    logic [1:0]           state_q, state_d;
    logic                 sign_q, zero_q;
    logic [Ne-1:0]        expA_q, expB_q;
    float                 res_q, res_d;
    logic                 accept, mulDone;
    logic [PW-1:0]        prod, prodN;
    logic signed [Ne+1:0] expSum, expNorm, expFinal;
    logic [Nm-1:0]        mantFinal;
    logic                 unusedBits;
`ifdef FLOAT_MUL_ROUND_EN
    logic                 roundUp, carry;
`endif

    assign accept = (state_q == ST_IDLE) && bus.start_i;

    mant_shift_add_mul #(.W(Nm + 1)) u_mul (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (accept),
        .a_i    ({1'b1, bus.op1_i.m}),
        .b_i    ({1'b1, bus.op2_i.m}),
        .done_o (mulDone),
        .prod_o (prod)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start_i) state_d = ST_MUL;
            ST_MUL:  if (mulDone) state_d = ST_NORM;
            ST_NORM: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The product of two [1,2) mantissas is in [1,4); left-align so the leading one is the MSB.
    always_comb begin
        expSum    = $signed({2'b00, expA_q}) + $signed({2'b00, expB_q}) - BIAS_W;
        expNorm   = expSum + $signed({{(Ne+1){1'b0}}, prod[PW-1]});
        prodN     = prod[PW-1] ? prod : (prod << 1);
        mantFinal = prodN[PW-2 -: Nm];
        expFinal  = expNorm;
`ifdef FLOAT_MUL_ROUND_EN
        roundUp            = prodN[Nm] && ((|prodN[Nm-1:0]) || mantFinal[0]);
        {carry, mantFinal} = {1'b0, mantFinal} + (Nm+1)'(roundUp);
        if (carry) begin
            expFinal = expNorm + EXP_ONE;
        end
        unusedBits = prodN[PW-1];
`else
        unusedBits = prodN[PW-1] | (|prodN[Nm:0]);
`endif
    end

    // Zero operands win over overflow, which wins over underflow; the sign survives all three.
    always_comb begin
        res_d.s = sign_q;
        res_d.e = '0;
        res_d.m = '0;
        if (!zero_q) begin
            if (expFinal >= EXP_MAX) begin
                res_d.e = '1;
            end else if (!expFinal[Ne+1] && (expFinal != '0)) begin
                res_d.e = expFinal[Ne-1:0];
                res_d.m = mantFinal;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            expA_q  <= '0;
            expB_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                sign_q <= bus.op1_i.s ^ bus.op2_i.s;
                zero_q <= float_is_zero(bus.op1_i) || float_is_zero(bus.op2_i);
                expA_q <= bus.op1_i.e;
                expB_q <= bus.op2_i.e;
            end
            if (state_q == ST_NORM) begin
                res_q <= res_d;
            end
        end
    end

    assign bus.busy_o = (state_q != ST_IDLE);
    assign bus.done_o = (state_q == ST_DONE);
    assign bus.res_o  = res_q;

endmodule

// File: tb/tb_float_mul_unit.sv
// Bench for float_mul_unit (Ne=8, Nm=23): directed vectors with literal results plus a
// cycle-level arithmetic model compared against busy/done/res on every cycle.
module tb_float_mul_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    float_mul_unit_if ifc ();

    float_mul_unit dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Exact integer product of the two significands, then normalize, round and saturate.
    function automatic logic [31:0] modelMul(input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, p, mant, rem, half;
        int e, sh;
        logic s;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        ma = 64'h80_0000 | 64'(a[22:0]);
        mb = 64'h80_0000 | 64'(b[22:0]);
        p  = ma * mb;
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        sh = 23;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end
        mant = p >> sh;
        rem  = p & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
`ifdef FLOAT_MUL_ROUND_EN
        if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
        if (mant == (64'd1 << 24)) begin
            mant = 64'd1 << 23;
            e    = e + 1;
        end
`else
        if (rem > half) mant = mant;
`endif
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], mant[22:0]};
    endfunction

    logic        sampStart = 1'b0;
    logic        sampRst = 1'b1;
    logic [31:0] sampA = '0;
    logic [31:0] sampB = '0;

    always @(posedge clk) begin
        sampStart <= ifc.start_i;
        sampRst   <= rst;
        sampA     <= ifc.op1_i;
        sampB     <= ifc.op2_i;
    end

    // age counts edges since accept: done_o occupies the cycle after edge 25, so it is
    // sampled by the 26th edge; the 26th edge returns the unit to idle.
    bit          pend = 1'b0;
    int          age = 0;
    logic [31:0] pendRes = '0;
    logic [31:0] heldRes = '0;
    bit          expDone;

    always @(negedge clk) begin
        expDone = 1'b0;
        if (sampRst) begin
            pend    = 1'b0;
            heldRes = '0;
        end else if (pend) begin
            age = age + 1;
            if (age == 26) pend = 1'b0;
        end else if (sampStart) begin
            pend    = 1'b1;
            age     = 0;
            pendRes = modelMul(sampA, sampB);
        end
        if (pend && age == 25) begin
            expDone = 1'b1;
            heldRes = pendRes;
        end
        checkOutput("busy", {31'd0, ifc.busy_o}, {31'd0, pend});
        checkOutput("done", {31'd0, ifc.done_o}, {31'd0, expDone});
        checkOutput("res", ifc.res_o, heldRes);
    end

    task automatic startOp(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ifc.start_i = 1'b1;
        ifc.op1_i   = a;
        ifc.op2_i   = b;
        @(negedge clk);
        ifc.start_i = 1'b0;
    endtask

    // Returns the number of edges up to and including the one that samples done_o high.
    task automatic waitDone(output int lat);
        int edges = 0;
        lat = -1;
        while (edges < 60) begin
            if (ifc.done_o) begin
                lat = edges + 1;
                return;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        checkOutput("doneTimeout", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] want, input string name);
        int lat;
        startOp(a, b);
        waitDone(lat);
        checkOutput({name, "Latency"}, lat, 32'd26);
        checkOutput({name, "Res"}, ifc.res_o, want);
        checkOutput({name, "Model"}, modelMul(a, b), want);
    endtask

    initial begin
        int lat;
        ifc.start_i = 1'b0;
        ifc.op1_i   = '0;
        ifc.op2_i   = '0;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("resetBusy", {31'd0, ifc.busy_o}, 32'd0);
        checkOutput("resetDone", {31'd0, ifc.done_o}, 32'd0);
        checkOutput("resetRes", ifc.res_o, 32'd0);
        rst = 1'b0;

        applyStimulus(32'h3FC00000, 32'h40000000, 32'h40400000, "onePointFiveTimesTwo");
        applyStimulus(32'hBFC00000, 32'h3FC00000, 32'hC0100000, "negOnePointFiveSquared");
        applyStimulus(32'h00000000, 32'h40490FDB, 32'h00000000, "zeroTimesPi");
        applyStimulus(32'h80000000, 32'h3F800000, 32'h80000000, "negZeroTimesOne");
        applyStimulus(32'h3F800000, 32'hC0490FDB, 32'hC0490FDB, "oneTimesNegPi");
        applyStimulus(32'h7F000000, 32'h7F000000, 32'h7F800000, "overflow");
        applyStimulus(32'h00800000, 32'h00800000, 32'h00000000, "underflow");
        applyStimulus(32'hFF800000, 32'h3F800000, 32'hFF800000, "allOnesExponent");
`ifdef FLOAT_MUL_ROUND_EN
        applyStimulus(32'h3FC00000, 32'h3F800001, 32'h3FC00002, "tieRoundsEven");
`else
        applyStimulus(32'h3FC00000, 32'h3F800001, 32'h3FC00001, "truncate");
`endif

        startOp(32'hBFC00000, 32'h3FC00000);
        @(negedge clk);
        ifc.start_i = 1'b1;
        ifc.op1_i   = 32'h7F000000;
        ifc.op2_i   = 32'h7F000000;
        @(negedge clk);
        ifc.start_i = 1'b0;
        waitDone(lat);
        checkOutput("busyIgnoreLatency", lat, 32'd24);
        checkOutput("busyIgnoreRes", ifc.res_o, 32'hC0100000);
        repeat (4) @(negedge clk);

        startOp(32'h3FC00000, 32'h40000000);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abortRes", ifc.res_o, 32'd0);
        checkOutput("abortBusy", {31'd0, ifc.busy_o}, 32'd0);
        checkOutput("abortDone", {31'd0, ifc.done_o}, 32'd0);
        repeat (30) @(negedge clk);
        checkOutput("abortStillIdle", {31'd0, ifc.busy_o}, 32'd0);

        applyStimulus(32'h3FC00000, 32'h40000000, 32'h40400000, "afterAbort");
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
